// File: rtl/display_mode_ctrl_pkg.sv
// Shared constants and state encoding for the display mode sequencer.
// Imported by display_idle_timer and display_mode_ctrl.
package display_mode_ctrl_pkg;

  localparam logic [1:0] SEL_CLOCK     = 2'd0;
  localparam logic [1:0] SEL_ALARM     = 2'd1;
  localparam logic [1:0] SEL_STOPWATCH = 2'd2;
  localparam logic [1:0] SEL_TEMP      = 2'd3;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  typedef enum logic [1:0] {
    VIEW   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  function automatic logic [1:0] field_of(
    input state_t s
  );
    logic [1:0] f;
    f = FIELD_NONE;
    unique case (s)
      VIEW:   f = FIELD_NONE;
      EDIT_H: f = FIELD_H;
      EDIT_M: f = FIELD_M;
      EDIT_S: f = FIELD_S;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/display_idle_timer.sv
// Saturating idle-seconds counter; done pulses on the tick that
// reaches TIMEOUT_S, so the caller can act on that same edge.
module display_idle_timer
  import display_mode_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int TMR_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic run,
  input  logic tick,
  output logic done
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_S - 1);
  localparam logic [TMR_W-1:0] TOP  = TMR_W'(TIMEOUT_S);

  logic [TMR_W-1:0] count;

  assign done = en & run & tick & ~clear & (count >= LAST);

  // Count ticks while running; clear on button, idle stop or timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      if (clear || !run || done) begin
        count <= '0;
      end else if (tick && count != TOP) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mux sequencer with field edit, blink and idle auto-return.
// Optional DISP_CTRL_ALARM_FORCE_EN: ringing alarm forces clock view.
module display_mode_ctrl
  import display_mode_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int TMR_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       alarm_ring,
  output logic [1:0] switch,
  output logic [1:0] edit_field,
  output logic       edit_target,
  output logic       blink
);

  state_t     state;
  state_t     nxt;
  logic [1:0] sw_n;
  logic [1:0] fld_n;
  logic       tgt_n;
  logic       blink_n;
  logic       btn;
  logic       run;
  logic       done;
  logic       force_clk;
  logic [1:0] sel;

  assign btn = btn_mode | btn_set;
  assign run = (state != VIEW) | (switch != SEL_CLOCK);

`ifdef DISP_CTRL_ALARM_FORCE_EN
  assign force_clk = alarm_ring & (state == VIEW);
`else
  logic unused_alarm;
  assign unused_alarm = alarm_ring;
  assign force_clk    = 1'b0;
`endif

  assign sel = force_clk ? SEL_CLOCK : switch;

  display_idle_timer #(
    .TIMEOUT_S (TIMEOUT_S),
    .TMR_W     (TMR_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (btn),
    .run   (run),
    .tick  (tick_1hz),
    .done  (done)
  );

  // Next state and next output values; timeout overrides everything.
  always_comb begin
    nxt     = state;
    sw_n    = switch;
    tgt_n   = edit_target;
    blink_n = blink;
    if (done) begin
      nxt     = VIEW;
      sw_n    = SEL_CLOCK;
      blink_n = 1'b0;
    end else begin
      unique case (state)
        VIEW: begin
          blink_n = 1'b0;
          sw_n    = sel;
          if (btn_set) begin
            if (!sel[1]) begin
              nxt   = EDIT_H;
              tgt_n = sel[0];
            end
          end else if (btn_mode && !force_clk) begin
            sw_n = switch + 2'd1;
          end
        end
        EDIT_H: begin
          if (btn_set) begin
            nxt     = EDIT_M;
            blink_n = 1'b0;
          end else if (tick_1hz) begin
            blink_n = ~blink;
          end
        end
        EDIT_M: begin
          if (btn_set) begin
            nxt     = EDIT_S;
            blink_n = 1'b0;
          end else if (tick_1hz) begin
            blink_n = ~blink;
          end
        end
        EDIT_S: begin
          if (btn_set) begin
            nxt     = VIEW;
            blink_n = 1'b0;
          end else if (tick_1hz) begin
            blink_n = ~blink;
          end
        end
      endcase
    end
    fld_n = field_of(nxt);
  end

  // State and registered outputs, frozen while en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= VIEW;
      switch      <= SEL_CLOCK;
      edit_field  <= FIELD_NONE;
      edit_target <= 1'b0;
      blink       <= 1'b0;
    end else if (en) begin
      state       <= nxt;
      switch      <= sw_n;
      edit_field  <= fld_n;
      edit_target <= tgt_n;
      blink       <= blink_n;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with hand-computed expectations.
// Covers both builds of DISP_CTRL_ALARM_FORCE_EN.
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_set = 1'b0;
  logic       alarm_ring = 1'b0;
  logic [1:0] switch;
  logic [1:0] edit_field;
  logic       edit_target;
  logic       blink;

  int nvec = 0;
  int nerr = 0;

  display_mode_ctrl #(
    .TIMEOUT_S (10),
    .TMR_W     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .tick_1hz    (tick_1hz),
    .btn_mode    (btn_mode),
    .btn_set     (btn_set),
    .alarm_ring  (alarm_ring),
    .switch      (switch),
    .edit_field  (edit_field),
    .edit_target (edit_target),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given pulses; outputs sampled 1 ns after the edge.
  task automatic pulse(
    input logic m,
    input logic s,
    input logic t
  );
    btn_mode = m;
    btn_set  = s;
    tick_1hz = t;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_set  = 1'b0;
    tick_1hz = 1'b0;
  endtask

  initial begin
    int sw_seq[5];
    int fld_seq[4];
    sw_seq  = '{1, 2, 3, 0, 1};
    fld_seq = '{1, 2, 3, 0};

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_switch", switch, 0);
    check("rst_field", edit_field, 0);
    check("rst_blink", blink, 0);
    check("rst_target", edit_target, 0);
    reset = 1'b1;

    // mode cycling 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      pulse(1, 0, 0);
      check($sformatf("mode_seq%0d", i), switch, sw_seq[i]);
    end

    // back to switch 0: 2,3,0
    repeat (3) pulse(1, 0, 0);
    check("sw_back0", switch, 0);

    // clock edit walk, mode ignored in edit
    for (int i = 0; i < 4; i++) begin
      pulse(0, 1, 0);
      check($sformatf("clk_edit_fld%0d", i), edit_field, fld_seq[i]);
      check($sformatf("clk_edit_tgt%0d", i), edit_target, 0);
      if (i < 3) begin
        pulse(1, 0, 0);
        check($sformatf("edit_mode_ign%0d", i), switch, 0);
        check($sformatf("edit_mode_fld%0d", i), edit_field, fld_seq[i]);
      end
    end

    // alarm edit with blink
    pulse(1, 0, 0);
    check("sw1", switch, 1);
    pulse(0, 1, 0);
    check("al_tgt", edit_target, 1);
    check("al_fld", edit_field, 1);
    check("al_blink0", blink, 0);
    pulse(0, 0, 1);
    check("blink_t1", blink, 1);
    pulse(0, 0, 1);
    check("blink_t2", blink, 0);
    pulse(0, 0, 1);
    check("blink_t3", blink, 1);
    pulse(0, 1, 0);
    check("al_fld_m", edit_field, 2);
    check("blink_clr_m", blink, 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("al_view_fld", edit_field, 0);
    check("al_view_sw", switch, 1);

    // set ignored on stopwatch
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    check("sw2_set_sw", switch, 2);
    check("sw2_set_fld", edit_field, 0);

    // timeout on the 10th tick
    for (int i = 1; i <= 10; i++) begin
      pulse(0, 0, 1);
      check($sformatf("to_tick%0d", i), switch, (i < 10) ? 2 : 0);
    end
    check("to_fld", edit_field, 0);

    // mode on 9th tick restarts the count
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    check("sw2_again", switch, 2);
    repeat (8) pulse(0, 0, 1);
    pulse(1, 0, 1);
    check("tick9_mode", switch, 3);
    pulse(0, 0, 1);
    check("tick10_noret", switch, 3);
    repeat (8) pulse(0, 0, 1);
    check("restart_9", switch, 3);
    pulse(0, 0, 1);
    check("restart_10", switch, 0);

    // reset mid-edit
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("pre_rst_fld", edit_field, 2);
    check("pre_rst_tgt", edit_target, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("mid_rst_sw", switch, 0);
    check("mid_rst_fld", edit_field, 0);
    check("mid_rst_tgt", edit_target, 0);
    check("mid_rst_blink", blink, 0);

    // simultaneous mode and set: set wins
    pulse(1, 1, 0);
    check("both_fld", edit_field, 1);
    check("both_sw", switch, 0);
    check("both_tgt", edit_target, 0);

    // en low freezes everything
    en = 1'b0;
    repeat (3) pulse(1, 1, 1);
    check("frz_fld", edit_field, 1);
    check("frz_sw", switch, 0);
    check("frz_blink", blink, 0);
    en = 1'b1;
    pulse(0, 0, 1);
    check("unfrz_blink", blink, 1);

    // set and timeout tick together: set wins
    repeat (8) pulse(0, 0, 1);
    check("pre_tie_blink", blink, 1);
    pulse(0, 1, 1);
    check("tie_fld", edit_field, 2);
    check("tie_blink", blink, 0);
    repeat (9) pulse(0, 0, 1);
    check("edit_to9_fld", edit_field, 2);
    check("edit_to9_blink", blink, 1);
    pulse(0, 0, 1);
    check("edit_to_fld", edit_field, 0);
    check("edit_to_sw", switch, 0);
    check("edit_to_blink", blink, 0);

    // alarm force
    repeat (3) pulse(1, 0, 0);
    check("pre_alarm_sw", switch, 3);
    alarm_ring = 1'b1;
    pulse(0, 0, 0);
`ifdef DISP_CTRL_ALARM_FORCE_EN
    check("alarm_force", switch, 0);
    pulse(1, 0, 0);
    check("alarm_mode_ign", switch, 0);
`else
    check("alarm_ignored", switch, 3);
    pulse(1, 0, 0);
    check("alarm_mode_ok", switch, 0);
`endif
    alarm_ring = 1'b0;
    pulse(1, 0, 0);
    check("post_alarm_sw", switch, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
Name: display_mode_ctrl

Overview:
- Sequencer for the digital-clock display mux.
- Drives the 2-bit display select: 0 = clock, 1 = alarm, 2 = stopwatch, 3 = temp.
- Drives the field-edit controls used by the clock and alarm setting logic.
- Inputs are debounced one-cycle button pulses and the 1 Hz tick. Adds edit sequencing, field blink and an idle auto-return to clock view.

Parameters:
- TIMEOUT_S, 10, idle seconds before auto-return to clock view (range 1..2^TMR_W-1).
- TMR_W, 4, width of the idle-seconds counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  clock enable; when 0, all state holds and outputs are frozen
- tick_1hz  in  1  one-cycle pulse once per second
- btn_mode  in  1  one-cycle pulse, advances the display
- btn_set  in  1  one-cycle pulse, enters or advances edit
- alarm_ring  in  1  level, alarm currently sounding
- switch  out  2  display select to the mux
- edit_field  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds
- edit_target  out  1  0 = clock being edited, 1 = alarm being edited; valid when edit_field != 0
- blink  out  1  blank the digits of the field being edited while high

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset == 0 at a clk edge): state = VIEW, switch = 0, edit_field = 0, edit_target = 0, blink = 0, idle counter = 0.
- All outputs are registered; every response appears 1 cycle after the qualifying input edge.
- Inputs are sampled only when en == 1.
- FSM states: VIEW, EDIT_H, EDIT_M, EDIT_S.
- VIEW, btn_mode: switch = (switch + 1) mod 4 (3 wraps to 0).
- VIEW, btn_set: only when switch is 0 or 1 → EDIT_H, edit_target = switch[0]. When switch is 2 or 3, btn_set is ignored.
- EDIT_H → EDIT_M → EDIT_S → VIEW, each on btn_set. btn_mode is ignored in all edit states.
- switch holds its value throughout edit.
- edit_field = 1/2/3 in EDIT_H/M/S, 0 in VIEW.
- Simultaneous btn_mode and btn_set: btn_set wins and btn_mode is dropped.
- blink:
  - Toggles on each tick_1hz while in an edit state.
  - Forced to 0 on entering any edit state and on entering VIEW.
  - Held at 0 while in VIEW.
- Idle counter:
  - Cleared on any button pulse.
  - Otherwise increments on tick_1hz, saturating at TIMEOUT_S.
  - Reaching TIMEOUT_S → state = VIEW, switch = 0, edit_field = 0, blink = 0, counter cleared; applies in view or edit.
  - The counter only runs when switch != 0 or the state is an edit state. In VIEW with switch == 0 it stays at 0.
- A button pulse and the timeout-reaching tick in the same cycle: the button wins and the counter clears.
- Reset mid-edit: return to VIEW, switch = 0, nothing else retained.

Optional Feature:
- Macro: DISP_CTRL_ALARM_FORCE_EN.
- Defined:
  - While alarm_ring == 1 and state == VIEW, switch is forced to 0 and btn_mode is ignored.
  - When alarm_ring falls, the pre-alarm switch value is not restored (it stays 0).
  - Edit states are unaffected by alarm_ring.
- Undefined: alarm_ring is ignored and the port remains for interface stability.

Decomposition:
- Shared package:
  - display-select constants SEL_CLOCK = 0, SEL_ALARM = 1, SEL_STOPWATCH = 2, SEL_TEMP = 3;
  - edit-field constants FIELD_NONE/H/M/S;
  - FSM state encoding typedef.
- One natural sub-module: display_idle_timer (saturating seconds counter with clear, enable and a done flag).
- FSM and output registers stay in the top.

Test Plan:
- Reset → switch = 0, edit_field = 0, blink = 0. Then 5 btn_mode pulses → switch sequence 1, 2, 3, 0, 1.
- switch = 0, btn_set ×4 → edit_field 1, 2, 3, 0, edit_target = 0. btn_mode pulses during edit → switch stays 0.
- switch = 1, btn_set, then 3 tick_1hz → edit_target = 1, edit_field = 1, blink 1, 0, 1. Repeat with switch = 2 and btn_set → no change.
- switch = 2, no buttons, TIMEOUT_S = 10 ticks → switch = 0 exactly 1 cycle after the 10th tick. A btn_mode on the 9th tick cycle resets the count and gives no return.
- EDIT_M, reset low for 1 cycle → VIEW, switch = 0, edit_field = 0. Same cycle btn_mode + btn_set in VIEW with switch = 0 → EDIT_H, switch stays 0.
- en = 0 with buttons and ticks applied → all outputs frozen. With DISP_CTRL_ALARM_FORCE_EN: switch = 3, alarm_ring = 1 → switch = 0 next cycle, btn_mode ignored until alarm_ring falls.
